// File: rtl/serializer_arbiter_if.sv
// Requester handshake and serial-frame signals for serializer_arbiter.
interface serializer_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      serial_o;
  logic                      valid_o;
  logic                      sof_o;
  logic                      eof_o;
  logic [ID_W-1:0]           src_o;
  logic                      busy_o;

  modport master (
    output req_valid_i, req_data_i,
    input  req_ready_o, serial_o, valid_o, sof_o, eof_o, src_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i,
    output req_ready_o, serial_o, valid_o, sof_o, eof_o, src_o, busy_o
  );
endinterface

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter feeding a shared LSB-first serial channel, back-to-back frames.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module serializer_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4
) (
  input logic                 clk,
  input logic                 reset,
  serializer_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state, state_n;
  logic [DATA_W-1:0]  sreg, sreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [ID_W-1:0]    src, src_n;
  logic               serial, serial_n;
  logic               valid, valid_n;
  logic               sof, sof_n;
  logic               eof, eof_n;
`ifdef SER_PARITY_EN
  logic               par, par_n;
`endif

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;
  logic [DATA_W-1:0]  word;
  logic               last_bit;
  logic               window;
  logic               accept;
  logic [NUM_REQ-1:0] ready_c;

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = ID_W'((int'(ptr) + k) % int'(NUM_REQ));
      if (!found && bus.req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == winner) word = bus.req_data_i[i*DATA_W +: DATA_W];
    end
  end

`ifdef SER_PARITY_EN
  assign last_bit = (state == PARITY);
`else
  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
`endif

  // Reset closes the window so nothing is accepted while it is held.
  assign window = !reset && ((state == IDLE) || last_bit);
  assign accept = window && found;

  always_comb begin
    ready_c = '0;
    if (accept) ready_c[winner] = 1'b1;
  end

  assign bus.req_ready_o = ready_c;
  assign bus.serial_o    = serial;
  assign bus.valid_o     = valid;
  assign bus.sof_o       = sof;
  assign bus.eof_o       = eof;
  assign bus.src_o       = src;
  assign bus.busy_o      = valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      ptr    <= ID_W'(NUM_REQ - 1);
      src    <= '0;
      serial <= 1'b0;
      valid  <= 1'b0;
      sof    <= 1'b0;
      eof    <= 1'b0;
`ifdef SER_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      sreg   <= sreg_n;
      cnt    <= cnt_n;
      ptr    <= ptr_n;
      src    <= src_n;
      serial <= serial_n;
      valid  <= valid_n;
      sof    <= sof_n;
      eof    <= eof_n;
`ifdef SER_PARITY_EN
      par    <= par_n;
`endif
    end
  end

  // Next-state and registered frame outputs; accept wins over end-of-frame.
  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    cnt_n    = cnt;
    ptr_n    = ptr;
    src_n    = src;
    serial_n = serial;
    valid_n  = valid;
    sof_n    = sof;
    eof_n    = eof;
`ifdef SER_PARITY_EN
    par_n    = par;
`endif
    if (accept) begin
      state_n  = SHIFT;
      sreg_n   = word;
      cnt_n    = '0;
      ptr_n    = winner;
      src_n    = winner;
      serial_n = word[0];
      valid_n  = 1'b1;
      sof_n    = 1'b1;
      eof_n    = 1'b0;
`ifdef SER_PARITY_EN
      par_n    = ^word;
`endif
    end else if (last_bit) begin
      state_n  = IDLE;
      sreg_n   = '0;
      cnt_n    = '0;
      serial_n = 1'b0;
      valid_n  = 1'b0;
      sof_n    = 1'b0;
      eof_n    = 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          sof_n = 1'b0;
          cnt_n = CNT_W'(cnt + CNT_W'(1));
`ifdef SER_PARITY_EN
          if (cnt == LAST_CNT) begin
            state_n  = PARITY;
            serial_n = par;
            eof_n    = 1'b1;
          end else begin
            sreg_n   = sreg >> 1;
            serial_n = sreg[1];
            eof_n    = 1'b0;
          end
`else
          sreg_n   = sreg >> 1;
          serial_n = sreg[1];
          eof_n    = (cnt_n == LAST_CNT);
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
